// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multiport register file.
package rf_pkg;

    // Register that reads as zero when the zero-register option is on.
    localparam int ZERO_ADDR  = 0;

    // Upper bound on write ports handled by the priority helper.
    localparam int MAX_PORTS  = 16;
    localparam int PORT_IDX_W = 4;

    // Number of registers for a given address width.
    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Index of the highest-numbered asserted bit; 0 when no bit is set.
    // The caller checks the OR of hits separately to know whether a hit exists.
    function automatic logic [PORT_IDX_W-1:0] highest_port(input logic [MAX_PORTS-1:0] hits);
        logic [PORT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (hits[i]) begin
                idx = PORT_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// popcount. Issue sets a bit, any write to the register clears it, and a
// same-edge issue beats the clear because the newer producer is still pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int WRITE_PORTS = 2,
    parameter int ZERO_REG    = 1,
    parameter int DEPTH       = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [WRITE_PORTS-1:0]        wr_en_i,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                          issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]         issue_addr_i,
    output logic [DEPTH-1:0]              busy_o,
    output logic [ADDR_WIDTH:0]           busy_count_o
);

    logic [DEPTH-1:0]    busy_q;
    logic [DEPTH-1:0]    busy_d;
    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] count_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic set_hit;
            logic clr_hit;

            // Any enabled write port targeting this register retires its producer.
            always_comb begin
                clr_hit = 1'b0;
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(gi))) begin
                        clr_hit = 1'b1;
                    end
                end
            end

            if ((ZERO_REG != 0) && (gi == ZERO_ADDR)) begin : g_zero
                assign set_hit = 1'b0;
            end else begin : g_normal
                assign set_hit = issue_valid_i && (issue_addr_i == ADDR_WIDTH'(gi));
            end

            assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
        end
    endgenerate

    // Population count of the next busy vector so the count tracks the bits on the same edge.
    always_comb begin
        count_d = '0;
        for (int a = 0; a < DEPTH; a++) begin
            count_d = count_d + (ADDR_WIDTH+1)'(busy_d[a]);
        end
    end

    // Busy bits and count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/multiport_register_file.sv
// N-read / M-write register file with optional write-to-read bypass,
// optional hardwired zero register and a pending-write scoreboard used by
// decode-stage hazard detection.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_address_i,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  read_data_o,
    output logic [READ_PORTS-1:0]             read_busy_o,
    input  logic [WRITE_PORTS-1:0]            write_enable_i,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_address_i,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data_i,
    input  logic                              issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]             issue_address_i,
    output logic [ADDR_WIDTH:0]               busy_count_o
);

    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_addr   [WRITE_PORTS];
    logic [DATA_WIDTH-1:0] wr_data   [WRITE_PORTS];
    logic [WRITE_PORTS-1:0] wr_en_eff;
    logic [DEPTH-1:0]      busy_vec;

    genvar gi;

    // Unpack write ports; writes to the zero register are dropped here so
    // neither storage, bypass nor scoreboard ever sees them.
    generate
        for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_wport
            assign wr_addr[gi] = write_address_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wr_data[gi] = write_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            if (ZERO_REG != 0) begin : g_zdrop
                assign wr_en_eff[gi] = write_enable_i[gi] && (wr_addr[gi] != ADDR_WIDTH'(ZERO_ADDR));
            end else begin : g_nodrop
                assign wr_en_eff[gi] = write_enable_i[gi];
            end
        end
    endgenerate

    // Storage: later ports overwrite earlier ones so the highest index wins a conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_en_eff[w]) begin
                    regs_q[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WRITE_PORTS (WRITE_PORTS),
        .ZERO_REG    (ZERO_REG),
        .DEPTH       (DEPTH)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_en_i       (wr_en_eff),
        .wr_addr_i     (write_address_i),
        .issue_valid_i (issue_valid_i),
        .issue_addr_i  (issue_address_i),
        .busy_o        (busy_vec),
        .busy_count_o  (busy_count_o)
    );

    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_rport
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic [MAX_PORTS-1:0]  rd_hits;
            logic [PORT_IDX_W-1:0] rd_win;
            logic [DATA_WIDTH-1:0] byp_data;
            logic [DATA_WIDTH-1:0] rd_val;
            logic                  rd_busy;
            logic                  rd_is_zero;
            logic                  issue_hit;

            assign rd_addr   = read_address_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign issue_hit = issue_valid_i && (issue_address_i == rd_addr);

            if (ZERO_REG != 0) begin : g_zchk
                assign rd_is_zero = (rd_addr == ADDR_WIDTH'(ZERO_ADDR));
            end else begin : g_nozchk
                assign rd_is_zero = 1'b0;
            end

            // Which write ports target this read address in the current cycle.
            always_comb begin
                rd_hits = '0;
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    rd_hits[w] = wr_en_eff[w] && (wr_addr[w] == rd_addr);
                end
            end

            assign rd_win = highest_port(rd_hits);

            // Select the winning port's data for the bypass path.
            always_comb begin
                byp_data = '0;
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (PORT_IDX_W'(w) == rd_win) begin
                        byp_data = wr_data[w];
                    end
                end
            end

            // Read data: stored value, optionally bypassed; zero register and reset force 0.
            always_comb begin
                rd_val = regs_q[rd_addr];
                if ((BYPASS != 0) && (|rd_hits)) begin
                    rd_val = byp_data;
                end
                if (rd_is_zero || !rst_ni) begin
                    rd_val = '0;
                end
            end

            // Busy view: registered bit, cleared early when a retiring write is visible on the bypass.
            always_comb begin
                rd_busy = busy_vec[rd_addr];
                if ((BYPASS != 0) && (|rd_hits) && !issue_hit) begin
                    rd_busy = 1'b0;
                end
                if (rd_is_zero) begin
                    rd_busy = 1'b0;
                end
            end

            assign read_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_val;
            assign read_busy_o[gi]                          = rd_busy;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised bench for multiport_register_file with a behavioural model:
// plain register/busy arrays updated from the architectural rules.
module tb_multiport_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int NREG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] ra [RP];
    logic [WP-1:0] we;
    logic [AW-1:0] wa [WP];
    logic [DW-1:0] wd [WP];
    logic          iv;
    logic [AW-1:0] ia;

    logic [RP*AW-1:0] read_address;
    logic [RP*DW-1:0] read_data;
    logic [RP-1:0]    read_busy;
    logic [WP*AW-1:0] write_address;
    logic [WP*DW-1:0] write_data;
    logic [AW:0]      busy_count;

    assign read_address  = {ra[1], ra[0]};
    assign write_address = {wa[1], wa[0]};
    assign write_data    = {wd[1], wd[0]};

    multiport_register_file #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .READ_PORTS (RP),
        .WRITE_PORTS (WP), .ZERO_REG (1), .BYPASS (1)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .read_address_i  (read_address),
        .read_data_o     (read_data),
        .read_busy_o     (read_busy),
        .write_enable_i  (we),
        .write_address_i (write_address),
        .write_data_i    (write_data),
        .issue_valid_i   (iv),
        .issue_address_i (ia),
        .busy_count_o    (busy_count)
    );

    // Reference state
    logic [DW-1:0] m_mem  [NREG];
    bit            m_busy [NREG];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        for (int w = 0; w < WP; w++)
            if (we[w] && wa[w] == a) v = wd[w];
        return v;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        for (int w = 0; w < WP; w++)
            if (we[w] && wa[w] == a && !(iv && ia == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_count();
        int n = 0;
        for (int a = 0; a < NREG; a++) n += m_busy[a];
        return n;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < NREG; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int w = 0; w < WP; w++) begin
            if (we[w] && wa[w] != 0) begin
                m_mem[wa[w]]  = wd[w];
                m_busy[wa[w]] = 1'b0;
            end
        end
        if (iv && ia != 0) m_busy[ia] = 1'b1;
    endtask

    task automatic set_idle();
        for (int r = 0; r < RP; r++) ra[r] = '0;
        for (int w = 0; w < WP; w++) begin
            wa[w] = '0;
            wd[w] = '0;
        end
        we = '0;
        iv = 1'b0;
        ia = '0;
    endtask

    // One transaction: check combinational outputs, clock, check registered count.
    task automatic step(input string tag);
        #2;
        for (int r = 0; r < RP; r++) begin
            check($sformatf("%s.rdata%0d", tag, r), 64'(read_data[r*DW +: DW]), 64'(exp_data(ra[r])));
            check($sformatf("%s.rbusy%0d", tag, r), 64'(read_busy[r]), 64'(exp_busy(ra[r])));
        end
        check($sformatf("%s.count_pre", tag), 64'(busy_count), 64'(exp_count()));
        @(posedge clk);
        model_edge();
        #1;
        check($sformatf("%s.count", tag), 64'(busy_count), 64'(exp_count()));
        $display("txn %0d %s ra=%0d/%0d we=%b wa=%0d/%0d wd=%h/%h iv=%b ia=%0d cnt=%0d",
                 cyc, tag, ra[0], ra[1], we, wa[0], wa[1], wd[0], wd[1], iv, ia, busy_count);
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        ra[0] = 5'd3;
        ra[1] = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        check("reset.rdata0", 64'(read_data[DW-1:0]), 64'h0);
        check("reset.rdata1", 64'(read_data[2*DW-1:DW]), 64'h0);
        check("reset.rbusy", 64'(read_busy), 64'h0);
        check("reset.count", 64'(busy_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bypass then stored value
        set_idle(); we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hC0; ra[0] = 5'd3;
        #1; check("byp.r3", 64'(read_data[DW-1:0]), 64'hC0);
        step("byp");
        set_idle(); ra[0] = 5'd3;
        #1; check("stored.r3", 64'(read_data[DW-1:0]), 64'hC0);
        step("stored");

        // Write conflict: highest port wins
        set_idle(); we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h11; wd[1] = 32'h22;
        step("conflict");
        set_idle(); ra[0] = 5'd7;
        #1; check("conflict.r7", 64'(read_data[DW-1:0]), 64'h22);
        step("conflict_rd");

        // Zero register
        set_idle(); we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; iv = 1'b1; ia = 5'd0;
        step("zero");
        set_idle();
        #1; check("zero.r0", 64'(read_data[DW-1:0]), 64'h0);
        check("zero.count", 64'(busy_count), 64'h0);

        // Scoreboard set / clear / set-wins
        set_idle(); iv = 1'b1; ia = 5'd5;
        step("issue5");
        set_idle(); ra[0] = 5'd5;
        #1; check("issue5.busy", 64'(read_busy[0]), 64'h1);
        check("issue5.count", 64'(busy_count), 64'h1);
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h338;
        step("write5");
        check("write5.count", 64'(busy_count), 64'h0);
        set_idle(); ra[0] = 5'd5; iv = 1'b1; ia = 5'd5; we[1] = 1'b1; wa[1] = 5'd5; wd[1] = 32'h44;
        step("setwins");
        set_idle(); ra[0] = 5'd5;
        #1; check("setwins.busy", 64'(read_busy[0]), 64'h1);

        // Reset mid-cycle discards the pending write
        set_idle(); iv = 1'b1; ia = 5'd2; we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'h3;
        ra[0] = 5'd4; ra[1] = 5'd5;
        #2; rst_n = 1'b0;
        #1;
        check("midrst.rdata0", 64'(read_data[DW-1:0]), 64'h0);
        check("midrst.rdata1", 64'(read_data[2*DW-1:DW]), 64'h0);
        check("midrst.rbusy", 64'(read_busy), 64'h0);
        check("midrst.count", 64'(busy_count), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        set_idle(); rst_n = 1'b1;
        ra[0] = 5'd4; ra[1] = 5'd7;
        @(posedge clk);
        #1;
        check("midrst.r4", 64'(read_data[DW-1:0]), 64'h0);
        check("midrst.r7", 64'(read_data[2*DW-1:DW]), 64'h0);

        // Random traffic concentrated on a few registers to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < RP; r++) ra[r] = AW'($urandom_range(0, 7));
            for (int w = 0; w < WP; w++) begin
                wa[w] = AW'($urandom_range(0, 7));
                wd[w] = $urandom;
            end
            we = WP'($urandom_range(0, 3));
            iv = 1'($urandom_range(0, 1));
            ia = AW'($urandom_range(0, 7));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
